keypad_cmd_encoder: RTL and testbench

Scans a 4×4 matrix keypad, debounces presses, and produces the 4-bit `cmd` code that `calc_top` consumes. It drives the keypad columns, reads the rows, and maps each accepted key to a calculator command. Each press yields exactly one command window. It sits between the board keypad pins and the `cmd` input of `calc_top`.

---
 rtl/calc_pkg.sv | 48 ++++
 rtl/sync2.sv | 29 ++
 rtl/keypad_cmd_encoder.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_cmd_encoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator command codes, keypad-to-command map and keypad scanner
// state type, used by keypad_cmd_encoder and calc_top.
package calc_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_ADD  = 4'b1010;
  localparam cmd_t CMD_SUB  = 4'b1011;
  localparam cmd_t CMD_MUL  = 4'b1100;
  localparam cmd_t CMD_CLR  = 4'b1101;
  localparam cmd_t CMD_EQ   = 4'b1110;
  localparam cmd_t CMD_NONE = 4'b1111;

  // Indexed by {row, col}; entry 15 is the unused key.
  localparam cmd_t [15:0] KEYMAP = {
    CMD_NONE, CMD_EQ, CMD_CLR, CMD_MUL,
    CMD_SUB,  CMD_ADD, 4'd9,   4'd8,
    4'd7,     4'd6,    4'd5,   4'd4,
    4'd3,     4'd2,    4'd1,   4'd0
  };

  typedef enum logic [1:0] {
    KP_SCAN         = 2'd0,
    KP_DEBOUNCE     = 2'd1,
    KP_EMIT         = 2'd2,
    KP_WAIT_RELEASE = 2'd3
  } kp_state_t;

  // Rows are active-low; the lowest-index low row wins.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] r;
    if (!rows[0]) begin
      r = 2'd0;
    end else if (!rows[1]) begin
      r = 2'd1;
    end else if (!rows[2]) begin
      r = 2'd2;
    end else begin
      r = 2'd3;
    end
    return r;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous inputs,
// with a configurable reset value.
module sync2 #(
  parameter int unsigned           WIDTH     = 4,
  parameter logic [WIDTH-1:0]      RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_cmd_encoder.sv
// 4x4 keypad scanner/debouncer producing calc_top command windows.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_cmd_encoder
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned HOLD_CYCLES     = 4,
  parameter int unsigned REPEAT_CYCLES   = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output cmd_t       cmd,
  output logic       key_valid
);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  localparam int unsigned SW = $clog2(SCAN_DIV + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV);
  localparam logic [SW-1:0] SCAN_ONE  = SW'(1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] RPT_MAX   = RW'(REPEAT_CYCLES);
  localparam logic [RW-1:0] RPT_ONE   = RW'(1);

  logic [3:0] row_s;

  kp_state_t    state_q,     state_d;
  logic [1:0]   col_q,       col_d;
  logic [1:0]   row_q,       row_d;
  logic [3:0]   pat_q,       pat_d;
  cmd_t         code_q,      code_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] deb_cnt_q,  deb_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RW-1:0] rpt_cnt_q,  rpt_cnt_d;
  cmd_t         cmd_q,       cmd_d;
  logic         key_valid_q, key_valid_d;
  logic [3:0]   col_out_q,   col_out_d;

  // Idle keypad reads all-high, so the synchronizer resets to "no key".
  sync2 #(
    .WIDTH    (4),
    .RESET_VAL(4'hF)
  ) u_row_sync (
    .clk_i (clock),
    .rst_ni(reset),
    .d_i   (row_in),
    .q_o   (row_s)
  );

  // Scanner state machine: next state, latched key and counters.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    pat_d      = pat_q;
    code_d     = code_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rpt_cnt_d  = rpt_cnt_q;

    case (state_q)
      KP_SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = {SW{1'b0}};
          if (row_s != 4'hF) begin
            state_d   = KP_DEBOUNCE;
            pat_d     = row_s;
            row_d     = lowest_low_row(row_s);
            deb_cnt_d = {DW{1'b0}};
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          scan_cnt_d = (scan_cnt_q == SCAN_MAX) ? scan_cnt_q : scan_cnt_q + SCAN_ONE;
        end
      end

      KP_DEBOUNCE: begin
        if (row_s != pat_q) begin
          state_d    = KP_SCAN;
          col_d      = col_q + 2'd1;
          scan_cnt_d = {SW{1'b0}};
          deb_cnt_d  = {DW{1'b0}};
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_cnt_d  = {DW{1'b0}};
          rpt_cnt_d  = {RW{1'b0}};
          hold_cnt_d = {HW{1'b0}};
          code_d     = KEYMAP[{row_q, col_q}];
          if (KEYMAP[{row_q, col_q}] == CMD_NONE) begin
            state_d = KP_WAIT_RELEASE;
          end else begin
            state_d = KP_EMIT;
          end
        end else begin
          deb_cnt_d = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + DEB_ONE;
        end
      end

      KP_EMIT: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = KP_WAIT_RELEASE;
          hold_cnt_d = {HW{1'b0}};
          deb_cnt_d  = {DW{1'b0}};
          rpt_cnt_d  = {RW{1'b0}};
        end else begin
          hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_ONE;
        end
      end

      KP_WAIT_RELEASE: begin
        if (row_s == 4'hF) begin
          rpt_cnt_d = {RW{1'b0}};
          if (deb_cnt_q == DEB_LAST) begin
            state_d    = KP_SCAN;
            col_d      = 2'd0;
            scan_cnt_d = {SW{1'b0}};
            deb_cnt_d  = {DW{1'b0}};
          end else begin
            deb_cnt_d = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + DEB_ONE;
          end
        end else begin
          deb_cnt_d = {DW{1'b0}};
          // Repeat timer only runs while the original key pattern is held.
          if (AUTOREPEAT && (row_s == pat_q) && (code_q != CMD_NONE)) begin
            if (rpt_cnt_q == RPT_LAST) begin
              state_d    = KP_EMIT;
              hold_cnt_d = {HW{1'b0}};
              rpt_cnt_d  = {RW{1'b0}};
            end else begin
              rpt_cnt_d = (rpt_cnt_q == RPT_MAX) ? rpt_cnt_q : rpt_cnt_q + RPT_ONE;
            end
          end else begin
            rpt_cnt_d = {RW{1'b0}};
          end
        end
      end

      default: begin
        state_d    = KP_SCAN;
        col_d      = 2'd0;
        scan_cnt_d = {SW{1'b0}};
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    cmd_d       = CMD_NONE;
    key_valid_d = 1'b0;
    if (state_d == KP_EMIT) begin
      cmd_d       = code_d;
      key_valid_d = (state_q != KP_EMIT);
    end else begin
      cmd_d       = CMD_NONE;
      key_valid_d = 1'b0;
    end
    col_out_d = col_drive(col_d);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= KP_SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      pat_q       <= 4'hF;
      code_q      <= CMD_NONE;
      scan_cnt_q  <= {SW{1'b0}};
      deb_cnt_q   <= {DW{1'b0}};
      hold_cnt_q  <= {HW{1'b0}};
      rpt_cnt_q   <= {RW{1'b0}};
      cmd_q       <= CMD_NONE;
      key_valid_q <= 1'b0;
      col_out_q   <= 4'b1110;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pat_q       <= pat_d;
      code_q      <= code_d;
      scan_cnt_q  <= scan_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rpt_cnt_q   <= rpt_cnt_d;
      cmd_q       <= cmd_d;
      key_valid_q <= key_valid_d;
      col_out_q   <= col_out_d;
    end
  end

  assign cmd       = cmd_q;
  assign key_valid = key_valid_q;
  assign col_out   = col_out_q;

endmodule

// File: tb/tb_keypad_cmd_encoder.sv
// Randomized bench for keypad_cmd_encoder against a countdown-based keypad model.
module tb_keypad_cmd_encoder;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int HOLD     = 12;
  localparam int RPT      = 40;

  localparam int PH_SCAN = 0;
  localparam int PH_DEB  = 1;
  localparam int PH_EMIT = 2;
  localparam int PH_WAIT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  cmd;
  logic        key_valid;
  logic [15:0] pressed = 16'h0000;

  int n_vec = 0;
  int n_err = 0;
  int kv_cnt = 0;
  logic [3:0] kv_last_cmd = 4'hF;

  // Model state
  int         m_phase, m_col, m_row, m_left, m_rleft, m_code;
  logic [3:0] m_pat, m_rs1, m_rs2, m_cmd;
  logic       m_kv;

  keypad_cmd_encoder #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .cmd      (cmd),
    .key_valid(key_valid)
  );

  always #5 clock = ~clock;

  // Physical keypad: a pressed key pulls its row low when its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4'(r * 4 + c)] && !col_out[2'(c)]) row_in[2'(r)] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_SCAN; m_col = 0; m_row = 0; m_left = SCAN_DIV; m_rleft = RPT;
    m_code = 15; m_pat = 4'hF; m_rs1 = 4'hF; m_rs2 = 4'hF; m_cmd = 4'hF; m_kv = 1'b0;
  endtask

  task automatic start_emit();
    m_phase = PH_EMIT; m_left = HOLD; m_kv = 1'b1; m_cmd = 4'(m_code);
  endtask

  // One clock of keypad behaviour, from the row value sampled this cycle.
  task automatic model_step(input logic [3:0] rin);
    logic [3:0] rs;
    rs = m_rs2; m_rs2 = m_rs1; m_rs1 = rin;
    m_kv = 1'b0;
    case (m_phase)
      PH_SCAN: begin
        m_left--;
        if (m_left == 0) begin
          if (rs != 4'hF) begin
            m_phase = PH_DEB; m_pat = rs; m_left = DEB;
            for (int r = 3; r >= 0; r--) if (!rs[2'(r)]) m_row = r;
          end else begin
            m_col = (m_col + 1) % 4; m_left = SCAN_DIV;
          end
        end
      end
      PH_DEB: begin
        if (rs != m_pat) begin
          m_phase = PH_SCAN; m_col = (m_col + 1) % 4; m_left = SCAN_DIV;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_code = m_row * 4 + m_col;   // keymap is the identity on {r,c}
            m_rleft = RPT;
            if (m_code == 15) begin
              m_phase = PH_WAIT; m_left = DEB;
            end else begin
              start_emit();
            end
          end
        end
      end
      PH_EMIT: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = PH_WAIT; m_cmd = 4'hF; m_left = DEB; m_rleft = RPT;
        end
      end
      default: begin
        if (rs == 4'hF) begin
          m_left--;
          if (m_left == 0) begin
            m_phase = PH_SCAN; m_col = 0; m_left = SCAN_DIV;
          end
        end else begin
          m_left = DEB;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (rs == m_pat && m_code != 15) begin
          m_rleft--;
          if (m_rleft == 0) begin
            start_emit(); m_rleft = RPT;
          end
        end else begin
          m_rleft = RPT;
        end
`endif
      end
    endcase
  endtask

  task automatic cycle();
    logic [3:0] ecol;
    @(negedge clock);
    model_step(row_in);
    @(posedge clock);
    #1;
    ecol = 4'hF;
    ecol[2'(m_col)] = 1'b0;
    check_eq("cmd", {28'd0, cmd}, {28'd0, m_cmd});
    check_eq("key_valid", {31'd0, key_valid}, {31'd0, m_kv});
    check_eq("col_out", {28'd0, col_out}, {28'd0, ecol});
    if (key_valid) begin
      kv_cnt++;
      kv_last_cmd = cmd;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Waits (bounded) for the scan to move onto the given column.
  task automatic wait_col_enter(input logic [3:0] target);
    logic [3:0] prev;
    bit hit;
    prev = col_out;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      cycle();
      if (col_out == target && prev != target) hit = 1'b1;
      prev = col_out;
    end
    check_eq("wait_col", {31'd0, hit}, 32'd1);
  endtask

  task automatic press_key(input logic [15:0] mask, input logic [3:0] col, input int hold,
                           output int lat);
    kv_cnt = 0;
    wait_col_enter(col);
    pressed = mask;
    lat = -1;
    for (int i = 0; i < hold; i++) begin
      cycle();
      if (key_valid && lat < 0) lat = i + 1;
    end
    pressed = 16'h0000;
    run(30);
  endtask

  initial begin
    int lat;
    bit hit;
    logic [3:0] nc;
    logic [15:0] mask;

    model_reset();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_cmd", {28'd0, cmd}, 32'hF);
    check_eq("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check_eq("rst_col_out", {28'd0, col_out}, 32'hE);
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    model_reset();

    // Key {0,1} pressed on its driven column.
    press_key(16'h0002, 4'b1101, 40, lat);
    check_eq("k01_count", kv_cnt, 32'd1);
    check_eq("k01_code", {28'd0, kv_last_cmd}, 32'd1);
    check_eq("k01_latency", {31'd0, (lat >= 1 && lat <= 2 + SCAN_DIV + DEB + 1)}, 32'd1);

    // 5-cycle glitch on row 0 while column 2 is driven.
    kv_cnt = 0;
    wait_col_enter(4'b1011);
    pressed = 16'h0004;
    run(5);
    pressed = 16'h0000;
    hit = 1'b0;
    nc = 4'hF;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycle();
      if (col_out != 4'b1011) begin
        hit = 1'b1;
        nc = col_out;
      end
    end
    check_eq("glitch_left_col", {31'd0, hit}, 32'd1);
    check_eq("glitch_next_col", {28'd0, nc}, 32'h7);
    run(10);
    check_eq("glitch_count", kv_cnt, 32'd0);

    // Rows 1 and 2 on column 2: lowest row wins.
    press_key(16'h0440, 4'b1011, 40, lat);
    check_eq("multi_count", kv_cnt, 32'd1);
    check_eq("multi_code", {28'd0, kv_last_cmd}, 32'd6);

    // Key {3,2} -> CMD_EQ; key {3,3} -> nothing.
    press_key(16'h4000, 4'b1011, 40, lat);
    check_eq("k32_count", kv_cnt, 32'd1);
    check_eq("k32_code", {28'd0, kv_last_cmd}, 32'hE);
    press_key(16'h8000, 4'b0111, 40, lat);
    check_eq("k33_count", kv_cnt, 32'd0);

    // Long hold of key {2,2}.
    press_key(16'h0400, 4'b1011, 200, lat);
    check_eq("hold_code", {28'd0, kv_last_cmd}, 32'hA);
`ifdef KEYPAD_AUTOREPEAT_EN
    check_eq("hold_repeats", {31'd0, (kv_cnt >= 3)}, 32'd1);
`else
    check_eq("hold_count", kv_cnt, 32'd1);
`endif

    // Random presses, overlapping keys and short gaps.
    for (int n = 0; n < 16; n++) begin
      mask = 16'h0001 << $urandom_range(0, 15);
      if ($urandom_range(0, 2) == 0) mask = mask | (16'h0001 << $urandom_range(0, 15));
      pressed = mask;
      run($urandom_range(1, 60));
      pressed = 16'h0000;
      run($urandom_range(0, 30));
    end
    run(40);

    // Reset asserted in the 6th cycle of a command window.
    kv_cnt = 0;
    pressed = 16'h0002;
    hit = 1'b0;
    for (int i = 0; i < 80 && !hit; i++) begin
      cycle();
      if (key_valid) hit = 1'b1;
    end
    check_eq("mid_emit_kv_seen", {31'd0, hit}, 32'd1);
    run(5);
    check_eq("pre_reset_cmd", {28'd0, cmd}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_cmd", {28'd0, cmd}, 32'hF);
    check_eq("async_rst_col_out", {28'd0, col_out}, 32'hE);
    check_eq("async_rst_key_valid", {31'd0, key_valid}, 32'd0);
    pressed = 16'h0000;
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    model_reset();
    run(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
